// File: rtl/graycode_pkg.sv
// Shared definitions for the Gray-code counter/decoder pair: default code width,
// decoder state encoding and the Gray <-> binary conversion helpers.
package graycode_pkg;

  localparam int GRAY_WIDTH = 4;
  // Helpers work on a fixed wide vector; narrower codes are zero-extended,
  // which leaves the prefix-XOR result unchanged for any width up to this.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/graycode_decoder.sv
// Receive-side Gray-code decoder: converts the sampled code to binary, emits
// UP/DOWN pulses for legal +/-1 steps, accumulates net position, faults on jumps.
module graycode_decoder
  import graycode_pkg::*;
#(
  parameter int WIDTH     = GRAY_WIDTH,
  parameter int POS_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     CODE,
  input  logic                 CLR_ERR,
  output logic [WIDTH-1:0]     BIN,
  output logic                 UP_O,
  output logic                 DOWN_O,
  output logic [POS_WIDTH-1:0] POS,
  output logic                 VALID,
  output logic                 ERR,
  output logic [1:0]           DBG_STATE
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] code_r;
  logic [WIDTH-1:0] last_r;
  logic             seen_r;
  logic [WIDTH-1:0] code_bin;
  logic [WIDTH-1:0] last_bin;
  logic [WIDTH-1:0] d;
  logic             step_up;
  logic             step_dn;
  logic             step_bad;

  assign code_bin = WIDTH'(gray2bin(GRAY_MAX_W'(code_r)));
  assign last_bin = WIDTH'(gray2bin(GRAY_MAX_W'(last_r)));
  // Modular difference: wrap 15->0 reads as +1 and 0->15 as -1.
  assign d        = code_bin - last_bin;
  assign step_up  = (d == WIDTH'(1));
  assign step_dn  = (d == {WIDTH{1'b1}});
  assign step_bad = (d != '0) && !step_up && !step_dn;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // CLR_ERR is only looked at in FAULT, so it cannot mask a jump seen in TRACK.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (seen_r)   state_nxt = TRACK;
      TRACK:   if (step_bad) state_nxt = FAULT;
      FAULT:   if (CLR_ERR)  state_nxt = INIT;
      default:               state_nxt = INIT;
    endcase
  end

  always_comb begin
    VALID     = (state == TRACK);
    ERR       = (state == FAULT);
    DBG_STATE = state;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      code_r <= '0;
      last_r <= '0;
      seen_r <= 1'b0;
      BIN    <= '0;
      UP_O   <= 1'b0;
      DOWN_O <= 1'b0;
      POS    <= '0;
    end else begin
      code_r <= CODE;
      seen_r <= 1'b1;
      UP_O   <= 1'b0;
      DOWN_O <= 1'b0;
      case (state)
        INIT: begin
          if (seen_r) begin
            last_r <= code_r;
            BIN    <= code_bin;
          end
        end
        TRACK: begin
          if (step_up) begin
            UP_O   <= 1'b1;
            POS    <= POS + POS_WIDTH'(1);
            last_r <= code_r;
            BIN    <= code_bin;
          end else if (step_dn) begin
            DOWN_O <= 1'b1;
            POS    <= POS - POS_WIDTH'(1);
            last_r <= code_r;
            BIN    <= code_bin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_graycode_decoder.sv
// Directed bench for graycode_decoder: reset, up/down steps, wrap, fault and
// clear, long position wrap, and mid-stream reset.
module tb_graycode_decoder;
  import graycode_pkg::*;

  logic       CLK;
  logic       RST;
  logic [3:0] CODE;
  logic       CLR_ERR;
  logic [3:0] BIN;
  logic       UP_O;
  logic       DOWN_O;
  logic [7:0] POS;
  logic       VALID;
  logic       ERR;
  logic [1:0] DBG_STATE;

  int checks = 0;
  int errors = 0;
  int up_cnt;
  int err_cnt;

  graycode_decoder #(.WIDTH(4), .POS_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .CODE(CODE), .CLR_ERR(CLR_ERR),
    .BIN(BIN), .UP_O(UP_O), .DOWN_O(DOWN_O), .POS(POS),
    .VALID(VALID), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_bin(input int b);
    CODE = 4'(bin2gray(32'(b & 15)));
  endtask

  task automatic expect_out(input string tag, input logic [3:0] bin, input logic up,
                            input logic dn, input logic [7:0] pos, input logic valid,
                            input logic err);
    check({tag, ".bin"}, 32'(BIN), 32'(bin));
    check({tag, ".up"}, 32'(UP_O), 32'(up));
    check({tag, ".down"}, 32'(DOWN_O), 32'(dn));
    check({tag, ".pos"}, 32'(POS), 32'(pos));
    check({tag, ".valid"}, 32'(VALID), 32'(valid));
    check({tag, ".err"}, 32'(ERR), 32'(err));
  endtask

  always @(negedge CLK) begin
    if (UP_O && DOWN_O) check("up_and_down", 32'(1), 32'(0));
  end

  initial begin
    RST = 1'b1; CODE = 4'b0000; CLR_ERR = 1'b0;
    tick();
    expect_out("reset", 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("reset.state", 32'(DBG_STATE), 32'(INIT));

    RST = 1'b0;
    tick();
    check("rise.edge1.valid", 32'(VALID), 32'(0));
    tick();
    expect_out("rise.edge2", 4'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    // Gray 0001, 0011, 0010: three UP pulses back to back.
    CODE = 4'b0001; tick();
    check("up.lat.up", 32'(UP_O), 32'(0));
    CODE = 4'b0011; tick();
    expect_out("up1", 4'd1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
    CODE = 4'b0010; tick();
    expect_out("up2", 4'd2, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
    tick();
    expect_out("up3", 4'd3, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
    tick();
    expect_out("hold", 4'd3, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0);

    // Step down 3 -> 2 -> 1 -> 0 -> 15 (wrap).
    CODE = 4'b0011; tick();
    CODE = 4'b0001; tick();
    expect_out("dn2", 4'd2, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
    CODE = 4'b0000; tick();
    expect_out("dn1", 4'd1, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
    CODE = 4'b1000; tick();
    expect_out("dn0", 4'd0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    tick();
    expect_out("dn_wrap", 4'd15, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    tick();
    check("dn_wrap.pulse_end", 32'(DOWN_O), 32'(0));

    // 15 -> 0 is an UP step.
    CODE = 4'b0000; tick();
    tick();
    expect_out("up_wrap", 4'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    CODE = 4'b0001; tick();
    tick();
    expect_out("to1", 4'd1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);

    // Single-bit flip 0001 -> 1001 is bin 1 -> 14: illegal, even with CLR_ERR on that edge.
    CODE = 4'b1001; tick();
    CLR_ERR = 1'b1; tick();
    expect_out("fault", 4'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1);
    check("fault.state", 32'(DBG_STATE), 32'(FAULT));
    CLR_ERR = 1'b0; tick();
    expect_out("fault_hold", 4'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1);
    CLR_ERR = 1'b1; tick();
    expect_out("clr", 4'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    check("clr.state", 32'(DBG_STATE), 32'(INIT));
    CLR_ERR = 1'b0; tick();
    expect_out("resync", 4'd14, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);

    // 256 consecutive UP steps starting from bin 14, POS 1.
    up_cnt = 0;
    err_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      set_bin(15 + k);
      tick();
      if (UP_O) up_cnt++;
      if (ERR) err_cnt++;
      if (UP_O && up_cnt == 255) check("wrap255.pos", 32'(POS), 32'(0));
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      if (UP_O) up_cnt++;
      if (ERR) err_cnt++;
    end
    check("wrap.up_count", 32'(up_cnt), 32'(256));
    check("wrap.err_count", 32'(err_cnt), 32'(0));
    expect_out("wrap.end", 4'd14, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);

    // Walk to POS 5 (bins 15,0,1,2), then reset mid-stream.
    for (int k = 0; k < 4; k++) begin
      set_bin(15 + k);
      tick();
    end
    tick();
    expect_out("pos5", 4'd2, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
    RST = 1'b1; tick();
    expect_out("midrst", 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("midrst.state", 32'(DBG_STATE), 32'(INIT));
    RST = 1'b0; tick();
    check("midrst.edge1.valid", 32'(VALID), 32'(0));
    tick();
    expect_out("midrst.edge2", 4'd2, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    set_bin(3); tick();
    tick();
    expect_out("post_rst_up", 4'd3, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
